filter_weight_loader: RTL and testbench

//  Sequencer that loads one KxK filter from filter RAM into a parallel tap register bank.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/filter_weight_loader_if.sv | 27 ++
 rtl/filter_tap_regfile.sv | 33 +++
 rtl/filter_weight_loader.sv | 116 +++++++++++
 tb/tb_filter_weight_loader.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared conv-layer constants and the filter weight loader state encoding.
// The address counter and MAC array build against the same constants.
package conv_pkg;

   localparam int DATA_W   = 8;
   localparam int NUM_TAPS = 9;
   localparam int RAM_LAT  = 1;
   localparam int ADDR_W   = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FETCH,
      ST_DRAIN,
      ST_HOLD
   } loader_state_e;

   // Tap index width; it must also be able to hold the count NUM_TAPS itself.
   function automatic int idx_width(input int taps);
      return $clog2(taps + 1);
   endfunction

endpackage

// File: rtl/filter_weight_loader_if.sv
// Bundle between the weight loader, the filter-RAM address counter/RAM and the MAC array.
// Handshake: w_valid/w_ready; a filter transfers on a rising clk edge with both high.
// Once w_valid rises, w_flat is frozen and w_valid stays high until that transfer.
interface filter_weight_loader_if #(
   parameter int P_DATA_W   = conv_pkg::DATA_W,
   parameter int P_NUM_TAPS = conv_pkg::NUM_TAPS
);
   logic                           start;
   logic                           addr_cnt_en;
   logic                           filter_idx_msel;
   logic [P_DATA_W-1:0]            filter_ram_data;
   logic                           w_valid;
   logic                           w_ready;
   logic [P_NUM_TAPS*P_DATA_W-1:0] w_flat;
   logic                           busy;
   logic                           done;

   modport master (
      input  start, filter_ram_data, w_ready,
      output addr_cnt_en, filter_idx_msel, w_valid, w_flat, busy, done
   );

   modport slave (
      output start, filter_ram_data, w_ready,
      input  addr_cnt_en, filter_idx_msel, w_valid, w_flat, busy, done
   );
endinterface

// File: rtl/filter_tap_regfile.sv
// Parallel tap register bank: one indexed write port, every tap visible on a flat bus.
module filter_tap_regfile
   import conv_pkg::*;
#(
   parameter int P_DATA_W   = DATA_W,
   parameter int P_NUM_TAPS = NUM_TAPS,
   parameter int P_IDX_W    = idx_width(NUM_TAPS)
)(
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_we,
   input  logic [P_IDX_W-1:0]             i_idx,
   input  logic [P_DATA_W-1:0]            i_data,
   output logic [P_NUM_TAPS*P_DATA_W-1:0] o_flat
);

   logic [P_DATA_W-1:0] r_taps [P_NUM_TAPS];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < P_NUM_TAPS; k++) r_taps[k] <= '0;
      end else begin
         for (int k = 0; k < P_NUM_TAPS; k++) begin
            if (i_we && (i_idx == P_IDX_W'(k))) r_taps[k] <= i_data;
         end
      end
   end

   for (genvar g = 0; g < P_NUM_TAPS; g++) begin : g_flat
      assign o_flat[g*P_DATA_W +: P_DATA_W] = r_taps[g];
   end

endmodule

// File: rtl/filter_weight_loader.sv
// Loads one KxK filter from filter RAM into the tap bank and offers it to the MAC array.
module filter_weight_loader
   import conv_pkg::*;
#(
   parameter int P_DATA_W   = DATA_W,
   parameter int P_NUM_TAPS = NUM_TAPS,
   parameter int P_RAM_LAT  = RAM_LAT
)(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   filter_weight_loader_if.master io_wl,
   output loader_state_e          o_dbg_state
);

   localparam int IDX_W = idx_width(P_NUM_TAPS);

   loader_state_e        r_state;
   loader_state_e        w_next;
   logic [IDX_W-1:0]     r_fetch_cnt;
   logic [IDX_W-1:0]     r_wr_idx;
   logic [P_RAM_LAT-1:0] r_issue;
   logic                 r_done;
   logic                 w_addr_en;
   logic                 w_msel;
   logic                 w_valid;
   logic                 w_busy;
   logic                 w_cap;
   logic                 w_last_fetch;
   logic                 w_last_cap;

   // The issue pipe tracks which RAM read returns data this cycle, whatever the latency.
   assign w_cap        = r_issue[P_RAM_LAT-1] && ((r_state == ST_FETCH) || (r_state == ST_DRAIN));
   assign w_last_fetch = (r_fetch_cnt == IDX_W'(P_NUM_TAPS - 1));
   assign w_last_cap   = w_cap && (r_wr_idx == IDX_W'(P_NUM_TAPS - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_addr_en = 1'b0;
      w_msel    = 1'b0;
      w_valid   = 1'b0;
      w_busy    = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (io_wl.start) w_next = ST_CLEAR;
         end
         ST_CLEAR: begin
            w_addr_en = 1'b1;
            w_msel    = 1'b1;
            w_next    = ST_FETCH;
         end
         ST_FETCH: begin
            w_addr_en = 1'b1;
            if (w_last_fetch) w_next = ST_DRAIN;
         end
         // Leaving on the final capture itself puts W_VALID up on the very next cycle.
         ST_DRAIN: begin
            if (w_last_cap) w_next = ST_HOLD;
         end
         ST_HOLD: begin
            w_valid = 1'b1;
            if (io_wl.w_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fetch_cnt <= '0;
         r_wr_idx    <= '0;
         r_issue     <= '0;
         r_done      <= 1'b0;
      end else begin
         r_issue[0] <= (r_state == ST_FETCH);
         for (int i = 1; i < P_RAM_LAT; i++) r_issue[i] <= r_issue[i-1];
         if (r_state == ST_CLEAR) begin
            r_fetch_cnt <= '0;
            r_wr_idx    <= '0;
         end else begin
            if (r_state == ST_FETCH) r_fetch_cnt <= r_fetch_cnt + IDX_W'(1);
            if (w_cap)               r_wr_idx    <= r_wr_idx + IDX_W'(1);
         end
         r_done <= (r_state == ST_HOLD) && io_wl.w_ready;
      end
   end

   a_no_overcapture: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(w_cap && (r_wr_idx >= IDX_W'(P_NUM_TAPS))));

   filter_tap_regfile #(
      .P_DATA_W   (P_DATA_W),
      .P_NUM_TAPS (P_NUM_TAPS),
      .P_IDX_W    (IDX_W)
   ) u_taps (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_cap),
      .i_idx   (r_wr_idx),
      .i_data  (io_wl.filter_ram_data),
      .o_flat  (io_wl.w_flat)
   );

   assign io_wl.addr_cnt_en     = w_addr_en;
   assign io_wl.filter_idx_msel = w_msel;
   assign io_wl.w_valid         = w_valid;
   assign io_wl.busy            = w_busy;
   assign io_wl.done            = r_done;
   assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_filter_weight_loader.sv
// Drives two loaders (RAM latency 1 and 3) in lockstep against a cycle-schedule reference model.
module tb_filter_weight_loader;
   import conv_pkg::*;

   localparam int FW   = NUM_TAPS * DATA_W;
   localparam int LAT3 = 3;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic ready = 1'b0;
   bit   mon_en = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   filter_weight_loader_if #(.P_DATA_W(DATA_W), .P_NUM_TAPS(NUM_TAPS)) wl0 ();
   filter_weight_loader_if #(.P_DATA_W(DATA_W), .P_NUM_TAPS(NUM_TAPS)) wl3 ();
   loader_state_e dbg0, dbg3;

   filter_weight_loader #(.P_DATA_W(DATA_W), .P_NUM_TAPS(NUM_TAPS), .P_RAM_LAT(1)) dut_l1 (
      .i_clk(clk), .i_rst_n(rst_n), .io_wl(wl0), .o_dbg_state(dbg0));
   filter_weight_loader #(.P_DATA_W(DATA_W), .P_NUM_TAPS(NUM_TAPS), .P_RAM_LAT(LAT3)) dut_l3 (
      .i_clk(clk), .i_rst_n(rst_n), .io_wl(wl3), .o_dbg_state(dbg3));

   assign wl0.start   = start;
   assign wl3.start   = start;
   assign wl0.w_ready = ready;
   assign wl3.w_ready = ready;

   logic          o_en [2], o_msel [2], o_valid [2], o_busy [2], o_done [2];
   logic [FW-1:0] o_flat [2];
   assign o_en[0]    = wl0.addr_cnt_en;     assign o_en[1]    = wl3.addr_cnt_en;
   assign o_msel[0]  = wl0.filter_idx_msel; assign o_msel[1]  = wl3.filter_idx_msel;
   assign o_valid[0] = wl0.w_valid;         assign o_valid[1] = wl3.w_valid;
   assign o_busy[0]  = wl0.busy;            assign o_busy[1]  = wl3.busy;
   assign o_done[0]  = wl0.done;            assign o_done[1]  = wl3.done;
   assign o_flat[0]  = wl0.w_flat;          assign o_flat[1]  = wl3.w_flat;

   // ---------------- filter RAM + address counter models ----------------
   logic [DATA_W-1:0] mem [32];
   logic [4:0]        ram_cnt [2] = '{5'd0, 5'd0};
   logic [DATA_W-1:0] ram_pipe [2][LAT3];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (o_en[i]) ram_cnt[i] <= o_msel[i] ? 5'd0 : ram_cnt[i] + 5'd1;
         ram_pipe[i][0] <= mem[ram_cnt[i]];
         for (int j = 1; j < LAT3; j++) ram_pipe[i][j] <= ram_pipe[i][j-1];
      end
   end
   assign wl0.filter_ram_data = ram_pipe[0][0];
   assign wl3.filter_ram_data = ram_pipe[1][LAT3-1];

   // ---------------- reference model + scoreboard ----------------
   // Age counts cycles since START was accepted: 1 = reload, 2..N+1 = fetch,
   // N+lat+2 onward = filter offered until the handshake.
   bit            m_active [2];
   int            m_age [2];
   bit            m_done [2];
   logic [FW-1:0] m_flat [2] = '{default: '0};
   logic [FW-1:0] exp_q0 [$];
   logic [FW-1:0] exp_q3 [$];
   int            done_cnt [2];

   function automatic int valid_age(input int i);
      return NUM_TAPS + ((i == 0) ? 1 : LAT3) + 2;
   endfunction

   function automatic logic [FW-1:0] pack_mem();
      logic [FW-1:0] r;
      for (int k = 0; k < NUM_TAPS; k++) r[k*DATA_W +: DATA_W] = mem[k];
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_age[i]    = 0;
            m_done[i]   = 1'b0;
            m_flat[i]   = '0;
         end
         exp_q0.delete();
         exp_q3.delete();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!m_active[i]) begin
               m_done[i] = 1'b0;
               if (start) begin
                  m_active[i] = 1'b1;
                  m_age[i]    = 1;
                  if (i == 0) exp_q0.push_back(pack_mem());
                  else        exp_q3.push_back(pack_mem());
               end
            end else if (m_age[i] >= valid_age(i) && ready) begin
               m_active[i] = 1'b0;
               m_done[i]   = 1'b1;
               if (i == 0) m_flat[i] = exp_q0.pop_front();
               else        m_flat[i] = exp_q3.pop_front();
            end else begin
               m_age[i]++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            string         nm;
            bit            ev;
            logic [FW-1:0] front;
            nm = (i == 0) ? "lat1" : "lat3";
            ev = m_active[i] && (m_age[i] >= valid_age(i));
            check_eq({nm, "_en"},    FW'(o_en[i]),    FW'(m_active[i] && m_age[i] <= NUM_TAPS + 1));
            check_eq({nm, "_msel"},  FW'(o_msel[i]),  FW'(m_active[i] && m_age[i] == 1));
            check_eq({nm, "_valid"}, FW'(o_valid[i]), FW'(ev));
            check_eq({nm, "_busy"},  FW'(o_busy[i]),  FW'(m_active[i]));
            check_eq({nm, "_done"},  FW'(o_done[i]),  FW'(m_done[i]));
            if (ev) begin
               front = (i == 0) ? exp_q0[0] : exp_q3[0];
               check_eq({nm, "_flat_hold"}, o_flat[i], front);
            end else if (!m_active[i]) begin
               check_eq({nm, "_flat_keep"}, o_flat[i], m_flat[i]);
            end
            if (o_done[i]) done_cnt[i]++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      while ((wl0.busy || wl3.busy) && t < budget) begin
         tick();
         t++;
      end
      check_eq("idle_reached", FW'(wl0.busy | wl3.busy), FW'(0));
   endtask

   task automatic randomize_mem();
      for (int a = 0; a < 32; a++) mem[a] = DATA_W'($urandom_range(0, 255));
   endtask

   // ---------------- stimulus ----------------
   localparam logic [FW-1:0] DEFAULT_FLAT = FW'(72'h18_17_16_15_14_13_12_11_10);

   initial begin
      int lat1, lat3, d0, d3, t;
      for (int a = 0; a < 32; a++) mem[a] = DATA_W'(8'h10 + a);
      repeat (2) @(posedge clk);
      #2;
      mon_en = 1'b1;
      tick();
      check_eq("rst_state_lat1", FW'(dbg0), FW'(ST_IDLE));
      check_eq("rst_state_lat3", FW'(dbg3), FW'(ST_IDLE));
      check_eq("rst_flat_lat1", o_flat[0], '0);
      rst_n = 1'b1;
      tick();

      // Single load with READY high; measure START-to-VALID latency.
      ready = 1'b1;
      pulse_start();
      lat1 = -1;
      lat3 = -1;
      for (int n = 1; n < 40 && (lat1 < 0 || lat3 < 0); n++) begin
         if (lat1 < 0 && wl0.w_valid) lat1 = n;
         if (lat3 < 0 && wl3.w_valid) lat3 = n;
         tick();
      end
      check_eq("latency_lat1", FW'(lat1), FW'(12));
      check_eq("latency_lat3", FW'(lat3), FW'(14));
      wait_idle(40);
      tick();
      check_eq("t1_flat_lat1", o_flat[0], DEFAULT_FLAT);
      check_eq("t1_flat_lat3", o_flat[1], DEFAULT_FLAT);

      // Back-pressure: filter held for 20+ cycles.
      ready = 1'b0;
      pulse_start();
      repeat (14 + 20) tick();
      ready = 1'b1;
      wait_idle(40);
      tick();

      // Extra START pulses in FETCH and HOLD are ignored.
      ready = 1'b0;
      d0 = done_cnt[0];
      d3 = done_cnt[1];
      pulse_start();
      repeat (4) tick();
      pulse_start();
      repeat (12) tick();
      pulse_start();
      repeat (2) tick();
      ready = 1'b1;
      wait_idle(40);
      tick();
      check_eq("one_done_lat1", FW'(done_cnt[0] - d0), FW'(1));
      check_eq("one_done_lat3", FW'(done_cnt[1] - d3), FW'(1));

      // Asynchronous reset in the middle of FETCH, then a clean reload.
      pulse_start();
      repeat (4) tick();
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check_eq("async_rst_en",    FW'(o_en[i]),    FW'(0));
         check_eq("async_rst_busy",  FW'(o_busy[i]),  FW'(0));
         check_eq("async_rst_valid", FW'(o_valid[i]), FW'(0));
         check_eq("async_rst_flat",  o_flat[i],       '0);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      pulse_start();
      wait_idle(40);
      tick();
      check_eq("post_rst_flat_lat1", o_flat[0], DEFAULT_FLAT);
      check_eq("post_rst_flat_lat3", o_flat[1], DEFAULT_FLAT);

      // Back-to-back loads: new contents and START in the DONE cycle.
      ready = 1'b1;
      randomize_mem();
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         t = 0;
         while (!wl0.done && t < 40) begin
            tick();
            t++;
         end
         check_eq("b2b_done_seen", FW'(wl0.done), FW'(1));
         randomize_mem();
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      wait_idle(60);
      tick();
      check_eq("b2b_flat_lat1", o_flat[0], pack_mem());

      // Random START/READY traffic; RAM contents change only while both loaders idle.
      repeat (300) begin
         ready = $urandom_range(0, 1) == 1;
         start = $urandom_range(0, 3) == 0;
         if (!wl0.busy && !wl3.busy && $urandom_range(0, 3) == 0) randomize_mem();
         tick();
      end
      start = 1'b0;
      ready = 1'b1;
      wait_idle(60);
      tick();
      mon_en = 1'b0;
      check_eq("queue_empty_lat1", FW'(exp_q0.size()), FW'(0));
      check_eq("queue_empty_lat3", FW'(exp_q3.size()), FW'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
